// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM encoding and timing constants for the button conditioner.
package btn_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} inc_state_t;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int REPEAT_DELAY_DEF = 25_000_000;
    localparam int REPEAT_PERIOD_DEF = 5_000_000;
    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_REPEAT_DELAY = 10;
    localparam int SIM_REPEAT_PERIOD = 3;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw key inputs and conditioned strobes/levels.
interface button_conditioner_if;
    logic key_inc_n;
    logic key_wr_n;
    logic inc_pulse;
    logic wr_pulse;
    logic inc_held;
    logic wr_held;
    logic repeat_active;
    modport master (output key_inc_n, key_wr_n,
                    input  inc_pulse, wr_pulse, inc_held, wr_held, repeat_active);
    modport slave  (input  key_inc_n, key_wr_n,
                    output inc_pulse, wr_pulse, inc_held, wr_held, repeat_active);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: 2-flop synchroniser, counter debounce and press-edge detect for one active-low key.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic held,
    output logic press_edge
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          prev;
    logic          pressed_s;
    assign pressed_s = ~sync[1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync       <= 2'b11;
            cnt        <= '0;
            held       <= 1'b0;
            prev       <= 1'b0;
            press_edge <= 1'b0;
        end else begin
            sync <= {sync[0], key_n};
            // level flips on the sample that would bring the count to DEBOUNCE_CYCLES
            if (pressed_s == held)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                held <= pressed_s;
                cnt  <= '0;
            end else
                cnt <= cnt + 1'b1;
            prev       <= held;
            press_edge <= held & ~prev;
        end
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced inc/wr strobes with hold-to-repeat on inc and wr-priority collision handling.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input logic clk,
    input logic rst_n,
    button_conditioner_if.slave bus
);
    localparam int TW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    inc_state_t    state;
    logic [TW-1:0] timer;
    logic          pending;
    logic          inc_held, inc_edge, wr_held, wr_edge;
    logic          inc_emit, fire_req;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .rst_n(rst_n), .key_n(bus.key_inc_n), .held(inc_held), .press_edge(inc_edge)
    );
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr (
        .clk(clk), .rst_n(rst_n), .key_n(bus.key_wr_n), .held(wr_held), .press_edge(wr_edge)
    );

    assign bus.inc_held = inc_held;
    assign bus.wr_held  = wr_held;

    always_comb begin
        inc_emit = (state == IDLE   && inc_edge) ||
                   (state == HOLD   && inc_held && timer == TW'(REPEAT_DELAY - 1)) ||
                   (state == REPEAT && inc_held && timer == TW'(REPEAT_PERIOD - 1));
        fire_req = inc_emit | pending;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            timer             <= '0;
            pending           <= 1'b0;
            bus.inc_pulse     <= 1'b0;
            bus.wr_pulse      <= 1'b0;
            bus.repeat_active <= 1'b0;
        end else begin
            case (state)
                IDLE: if (inc_edge) begin
                    timer <= '0;
                    state <= HOLD;
                end
                HOLD: if (!inc_held)
                    state <= IDLE;
                else if (timer == TW'(REPEAT_DELAY - 1)) begin
                    timer <= '0;
                    state <= REPEAT;
                end else
                    timer <= timer + 1'b1;
                REPEAT: if (!inc_held)
                    state <= IDLE;
                else
                    timer <= (timer == TW'(REPEAT_PERIOD - 1)) ? '0 : timer + 1'b1;
                default: state <= IDLE;
            endcase
            // wr wins a collision; the inc strobe waits one cycle in pending
            bus.wr_pulse      <= wr_edge;
            bus.inc_pulse     <= fire_req & ~wr_edge;
            pending           <= wr_edge ? fire_req : (inc_emit & pending);
            bus.repeat_active <= (state == REPEAT);
        end
    end
endmodule
